piano_tone_decoder: RTL

Receiver-side counterpart of `piano_keyboard`: takes the keyboard's square-wave `audio_out` (or any external 1-bit tone) and determines which of the eight keyboard notes is sounding. It measures the period between consecutive rising edges and classifies each period against the shared note-period table. A note is reported only after a run of consistent periods. The block sits in the loop-back and self-check path beside the keyboard generator and drives LEDs and the verification scoreboard.

---
 rtl/piano_pkg.sv | 23 ++
 rtl/sync_edge_detect.sv | 24 ++
 rtl/piano_tone_decoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// Shared constants for the piano keyboard generator and tone decoder.
// The note-period table is indexed by note number (0 = C4 ... 7 = C5).
package piano_pkg;
  localparam int NUM_NOTES = 8;
  localparam int NOTE_W    = 3;
  localparam int PERIOD_W  = 19;

  typedef logic [PERIOD_W-1:0] period_t;
  typedef logic [NOTE_W-1:0]   note_t;

  // Tone periods in 50 MHz clk cycles, C4 in element 0.
  localparam logic [NUM_NOTES-1:0][PERIOD_W-1:0] NOTE_PERIOD = {
    19'd95556, 19'd101238, 19'd113636, 19'd127553,
    19'd143172, 19'd151685, 19'd170265, 19'd191113
  };

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} dec_state_t;

  function automatic logic [NUM_NOTES-1:0] note_onehot(input note_t idx);
    note_onehot      = '0;
    note_onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// Brings the asynchronous tone into the clk domain and flags its rising edges.
// rise is high for one cycle, two cycles after the input is first sampled high.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
endmodule

// File: rtl/piano_tone_decoder.sv
// Measures rising-edge to rising-edge periods of a 1-bit tone and reports the
// keyboard note once LOCK_COUNT consecutive periods agree with the same table entry.
module piano_tone_decoder
  import piano_pkg::*;
#(
  parameter int TOL        = 1024,
  parameter int LOCK_COUNT = 3,
  parameter int TIMEOUT    = 262144,
  parameter logic [NUM_NOTES-1:0][PERIOD_W-1:0] PERIODS = NOTE_PERIOD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 audio_in,
  output logic [NUM_NOTES-1:0] key,
  output logic [NOTE_W-1:0]    note_idx,
  output logic                 valid,
  output logic                 note_strobe,
  output logic [PERIOD_W-1:0]  period
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_C = MW'(LOCK_COUNT);
  localparam period_t TO_C  = PERIOD_W'(TIMEOUT);
  localparam period_t TOL_C = PERIOD_W'(TOL);

  logic rise;

  sync_edge_detect u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (audio_in),
    .rise (rise)
  );

  // Period counter: restarts at 1 on each edge so a sampled value equals the period.
  period_t cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cnt <= '0;
    else if (rise)         cnt <= PERIOD_W'(1);
    else if (cnt != TO_C)  cnt <= cnt + 1'b1;
  end

  logic [NUM_NOTES-1:0] hit;
  logic                 match;
  note_t                hit_idx;

  for (genvar i = 0; i < NUM_NOTES; i++) begin : g_cls
    period_t ref_p, diff;
    assign ref_p  = PERIODS[i];
    assign diff   = (cnt >= ref_p) ? cnt - ref_p : ref_p - cnt;
    assign hit[i] = (diff <= TOL_C);
  end

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NUM_NOTES; i++)
      if (hit[i]) hit_idx = NOTE_W'(i);
  end
  assign match = |hit;

  dec_state_t           state, state_nxt;
  note_t                cand, cand_nxt, idx_nxt;
  logic [MW-1:0]        mcnt, mcnt_nxt;
  logic [NUM_NOTES-1:0] key_nxt;
  logic                 valid_nxt, strobe_nxt;
  period_t              period_nxt;
  logic                 timeout;

  assign timeout = (cnt == TO_C) && !rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cand        <= '0;
      mcnt        <= '0;
      key         <= '0;
      note_idx    <= '0;
      valid       <= 1'b0;
      note_strobe <= 1'b0;
      period      <= '0;
    end else begin
      state       <= state_nxt;
      cand        <= cand_nxt;
      mcnt        <= mcnt_nxt;
      key         <= key_nxt;
      note_idx    <= idx_nxt;
      valid       <= valid_nxt;
      note_strobe <= strobe_nxt;
      period      <= period_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    mcnt_nxt   = mcnt;
    key_nxt    = key;
    idx_nxt    = note_idx;
    valid_nxt  = valid;
    strobe_nxt = 1'b0;
    period_nxt = period;

    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = ACQUIRE;
          mcnt_nxt  = '0;
        end
      end
      default: begin
        if (rise) begin
          period_nxt = cnt;
          if (!match) begin
            mcnt_nxt = '0;
          end else if (state == ACQUIRE && hit_idx == cand) begin
            mcnt_nxt = mcnt + 1'b1;
          end else begin
            cand_nxt = hit_idx;
            mcnt_nxt = MW'(1);
          end

          if (state == LOCKED) begin
            // Any disagreement drops the lock; a new note must re-qualify from scratch.
            if (!(match && hit_idx == cand)) begin
              state_nxt  = ACQUIRE;
              key_nxt    = '0;
              valid_nxt  = 1'b0;
              strobe_nxt = 1'b1;
            end
          end else if (mcnt_nxt >= LOCK_C) begin
            state_nxt  = LOCKED;
            key_nxt    = note_onehot(cand_nxt);
            idx_nxt    = cand_nxt;
            valid_nxt  = 1'b1;
            strobe_nxt = 1'b1;
          end
        end else if (timeout) begin
          state_nxt  = IDLE;
          mcnt_nxt   = '0;
          key_nxt    = '0;
          valid_nxt  = 1'b0;
          strobe_nxt = |key;
        end
      end
    endcase
  end
endmodule
